// File: rtl/vex_sched_pkg.sv
// Shared types and constants for the vector-lane execute stage scheduler.
package vex_sched_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int MICROOP_BIT_DEF = 9;
  localparam int MUL_LATENCY_DEF = 3;
  localparam int REG_ADDR_DEF    = 5;
  localparam int SEW_W           = 3;
  localparam int MIN_MUL_LATENCY = 2;
  localparam int MAX_MUL_LATENCY = 8;

  // Writeback packet for the default lane configuration.
  typedef struct packed {
    logic [REG_ADDR_DEF-1:0]     dest;
    logic [SEW_W-1:0]            sew;
    logic [DATA_WIDTH_DEF/8-1:0] mask;
    logic [DATA_WIDTH_DEF-1:0]   opc;
    logic [DATA_WIDTH_DEF-1:0]   result;
  } wb_pkt_t;

  // Issued micro-op fields for the default lane configuration.
  typedef struct packed {
    logic                        is_mul;
    logic [MICROOP_BIT_DEF-1:0]  op;
    logic [SEW_W-1:0]            sew;
    logic [REG_ADDR_DEF-1:0]     dest;
    logic [DATA_WIDTH_DEF-1:0]   opa;
    logic [DATA_WIDTH_DEF-1:0]   opb;
    logic [DATA_WIDTH_DEF-1:0]   opc;
    logic [DATA_WIDTH_DEF/8-1:0] mask;
  } exec_req_t;

  // Keeps the multiply latency inside the range the scheduler supports.
  function automatic int clamp_mul_latency(input int lat);
    int r;
    if (lat < MIN_MUL_LATENCY) begin
      r = MIN_MUL_LATENCY;
    end else if (lat > MAX_MUL_LATENCY) begin
      r = MAX_MUL_LATENCY;
    end else begin
      r = lat;
    end
    return r;
  endfunction

endpackage

// File: rtl/vex_sched_if.sv
// Issue / FU / writeback / load-wait bundle of the execute stage.
interface vex_sched_if
  import vex_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MICROOP_BIT = MICROOP_BIT_DEF,
  parameter int REG_ADDR    = REG_ADDR_DEF
);
  logic                    flush;
  logic                    issue_valid;
  logic                    issue_ready;
  logic                    issue_is_mul;
  logic [MICROOP_BIT-1:0]  issue_op;
  logic [SEW_W-1:0]        issue_sew;
  logic [REG_ADDR-1:0]     issue_dest;
  logic [DATA_WIDTH-1:0]   issue_opa;
  logic [DATA_WIDTH-1:0]   issue_opb;
  logic [DATA_WIDTH-1:0]   issue_opc;
  logic [DATA_WIDTH/8-1:0] issue_mask;

  logic [MICROOP_BIT-1:0]  fu_op;
  logic [SEW_W-1:0]        fu_sew;
  logic [DATA_WIDTH-1:0]   fu_opa;
  logic [DATA_WIDTH-1:0]   fu_opb;
  logic [DATA_WIDTH-1:0]   fu_opc;
  logic [DATA_WIDTH-1:0]   fu_simple_result;
  logic [DATA_WIDTH-1:0]   fu_mul_result;

  logic                    wait_load_in;
  logic [REG_ADDR-1:0]     load_dest_in;
  logic                    wait_load_out;
  logic [REG_ADDR-1:0]     load_dest_out;

  logic                    wb_valid;
  logic [REG_ADDR-1:0]     wb_dest;
  logic [SEW_W-1:0]        wb_sew;
  logic [DATA_WIDTH/8-1:0] wb_mask;
  logic [DATA_WIDTH-1:0]   wb_opc;
  logic [DATA_WIDTH-1:0]   wb_result;

  // Execute-stage side.
  modport slave (
    input  flush, issue_valid, issue_is_mul, issue_op, issue_sew, issue_dest,
           issue_opa, issue_opb, issue_opc, issue_mask,
           fu_simple_result, fu_mul_result, wait_load_in, load_dest_in,
    output issue_ready, fu_op, fu_sew, fu_opa, fu_opb, fu_opc,
           wait_load_out, load_dest_out,
           wb_valid, wb_dest, wb_sew, wb_mask, wb_opc, wb_result
  );

  // Issue / FU / writeback environment side.
  modport master (
    output flush, issue_valid, issue_is_mul, issue_op, issue_sew, issue_dest,
           issue_opa, issue_opb, issue_opc, issue_mask,
           fu_simple_result, fu_mul_result, wait_load_in, load_dest_in,
    input  issue_ready, fu_op, fu_sew, fu_opa, fu_opb, fu_opc,
           wait_load_out, load_dest_out,
           wb_valid, wb_dest, wb_sew, wb_mask, wb_opc, wb_result
  );

endinterface

// File: rtl/vex_latency_pipe.sv
// Valid + payload shift line; flush drops all valids, payload is don't-care when invalid.
module vex_latency_pipe #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic out_valid,
  output T     out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  T                 data_q [DEPTH];

  // Next valid vector: shift toward the output, or clear everything on flush.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
      end
      valid_d[0] = in_valid;
    end
  end

  // Valid and payload registers; payload shifts every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/vex_sched.sv
// Vector-lane execute stage: operand hold, writeback-slot reservation,
// multiply metadata pipeline and registered in-order-of-completion writeback.
module vex_sched
  import vex_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MICROOP_BIT = MICROOP_BIT_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int REG_ADDR    = REG_ADDR_DEF
) (
  input logic        clk,
  input logic        rst,
  vex_sched_if.slave bus
);

  localparam int MASK_W     = DATA_WIDTH / 8;
  localparam int LAT        = clamp_mul_latency(MUL_LATENCY);
  localparam int PIPE_DEPTH = LAT - 1;

  typedef struct packed {
    logic [MICROOP_BIT-1:0] op;
    logic [SEW_W-1:0]       sew;
    logic [DATA_WIDTH-1:0]  opa;
    logic [DATA_WIDTH-1:0]  opb;
    logic [DATA_WIDTH-1:0]  opc;
  } opnd_t;

  typedef struct packed {
    logic [REG_ADDR-1:0]   dest;
    logic [SEW_W-1:0]      sew;
    logic [MASK_W-1:0]     mask;
    logic [DATA_WIDTH-1:0] opc;
  } meta_t;

  typedef struct packed {
    logic [REG_ADDR-1:0]   dest;
    logic [SEW_W-1:0]      sew;
    logic [MASK_W-1:0]     mask;
    logic [DATA_WIDTH-1:0] opc;
    logic [DATA_WIDTH-1:0] result;
  } wb_t;

  logic                ready_s;
  logic                fire_s;
  logic                mul_fire_s;
  logic                simple_fire_s;
  logic [LAT:1]        res_q;
  logic [LAT:1]        res_d;
  opnd_t               issue_opnd_s;
  opnd_t               hold_q;
  opnd_t               hold_d;
  meta_t               issue_meta_s;
  meta_t               mul_meta_s;
  logic                mul_meta_valid_s;
  wb_t                 wb_q;
  wb_t                 wb_d;
  logic                wait_load_q;
  logic [REG_ADDR-1:0] load_dest_q;

  // res_q[1] is the slot retiring this cycle (it is wb_valid), so a simple op
  // firing now would land on the slot flagged by res_q[2]; multiplies bypass the check.
  always_comb begin
    ready_s = !(res_q[2] && !bus.issue_is_mul) && !bus.flush;
  end

  // Handshake qualification and per-path fire strobes.
  always_comb begin
    fire_s        = bus.issue_valid && ready_s;
    mul_fire_s    = fire_s && bus.issue_is_mul;
    simple_fire_s = fire_s && !bus.issue_is_mul;
  end

  // Pack the incoming operand and metadata fields.
  always_comb begin
    issue_opnd_s.op   = bus.issue_op;
    issue_opnd_s.sew  = bus.issue_sew;
    issue_opnd_s.opa  = bus.issue_opa;
    issue_opnd_s.opb  = bus.issue_opb;
    issue_opnd_s.opc  = bus.issue_opc;
    issue_meta_s.dest = bus.issue_dest;
    issue_meta_s.sew  = bus.issue_sew;
    issue_meta_s.mask = bus.issue_mask;
    issue_meta_s.opc  = bus.issue_opc;
  end

  // Operand bus: live issue fields on fire, otherwise the held copy; this is also the next hold value.
  always_comb begin
    if (fire_s) begin
      hold_d = issue_opnd_s;
    end else begin
      hold_d = hold_q;
    end
  end

  // Operand hold registers keep the FU inputs stable while a multiply is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Reservation shifter: a multiply claims the far slot, a simple op the nearest one.
  always_comb begin
    res_d = '0;
    if (bus.flush) begin
      res_d = '0;
    end else begin
      for (int k = 1; k < LAT; k++) begin
        res_d[k] = res_q[k+1];
      end
      res_d[LAT] = mul_fire_s;
      res_d[1]   = res_d[1] | simple_fire_s;
    end
  end

  // Reservation vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  vex_latency_pipe #(
    .DEPTH (PIPE_DEPTH),
    .T     (meta_t)
  ) u_meta_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (mul_fire_s),
    .in_data   (issue_meta_s),
    .out_valid (mul_meta_valid_s),
    .out_data  (mul_meta_s)
  );

  // Writeback capture: simple result on simple fire, multiply result when its metadata
  // reaches the end of the pipe; nothing is captured in a flush cycle.
  always_comb begin
    wb_d = wb_q;
    if (bus.flush) begin
      wb_d = wb_q;
    end else if (simple_fire_s) begin
      wb_d.dest   = bus.issue_dest;
      wb_d.sew    = bus.issue_sew;
      wb_d.mask   = bus.issue_mask;
      wb_d.opc    = bus.issue_opc;
      wb_d.result = bus.fu_simple_result;
    end else if (mul_meta_valid_s) begin
      wb_d.dest   = mul_meta_s.dest;
      wb_d.sew    = mul_meta_s.sew;
      wb_d.mask   = mul_meta_s.mask;
      wb_d.opc    = mul_meta_s.opc;
      wb_d.result = bus.fu_mul_result;
    end else begin
      wb_d = wb_q;
    end
  end

  // Writeback field register; fields hold their last value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // Load-wait passthrough, one register stage, unaffected by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_load_q <= 1'b0;
      load_dest_q <= '0;
    end else begin
      wait_load_q <= bus.wait_load_in;
      load_dest_q <= bus.load_dest_in;
    end
  end

  assign bus.issue_ready   = ready_s;
  assign bus.fu_op         = hold_d.op;
  assign bus.fu_sew        = hold_d.sew;
  assign bus.fu_opa        = hold_d.opa;
  assign bus.fu_opb        = hold_d.opb;
  assign bus.fu_opc        = hold_d.opc;
  assign bus.wb_valid      = res_q[1];
  assign bus.wb_dest       = wb_q.dest;
  assign bus.wb_sew        = wb_q.sew;
  assign bus.wb_mask       = wb_q.mask;
  assign bus.wb_opc        = wb_q.opc;
  assign bus.wb_result     = wb_q.result;
  assign bus.wait_load_out = wait_load_q;
  assign bus.load_dest_out = load_dest_q;

endmodule

// File: tb/tb_vex_sched.sv
// Scoreboard bench for vex_sched: stimulus pushes expected writebacks keyed by
// retirement cycle, a negedge monitor matches every wb_valid against them.
module tb_vex_sched;
  import vex_sched_pkg::*;

  localparam int DW = 64;
  localparam int MB = 9;
  localparam int RA = 5;
  localparam int ML = 3;

  typedef struct {
    int      cyc;
    wb_pkt_t pkt;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq [$];
  logic [DW-1:0] mp [ML];

  vex_sched_if #(.DATA_WIDTH(DW), .MICROOP_BIT(MB), .REG_ADDR(RA)) bus ();

  vex_sched #(
    .DATA_WIDTH  (DW),
    .MICROOP_BIT (MB),
    .MUL_LATENCY (ML),
    .REG_ADDR    (RA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FU model: simple path is opa^opb on the operand bus, multiply delivers opa*opb ML-1 cycles later.
  assign bus.fu_simple_result = bus.fu_opa ^ bus.fu_opb;
  assign bus.fu_mul_result    = mp[ML-1];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mp[0] <= (bus.issue_valid && bus.issue_ready && bus.issue_is_mul) ? bus.fu_opa * bus.fu_opb : 64'd0;
    for (int i = 1; i < ML; i++) mp[i] <= mp[i-1];
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: match wb_valid against the scoreboard, then flag any overdue entry.
  always @(negedge clk) begin : monitor
    int      idx;
    wb_pkt_t got;
    if (!rst) begin
      idx = -1;
      foreach (sbq[i]) if (sbq[i].cyc == cyc) idx = i;
      if (bus.wb_valid) begin
        got.dest = bus.wb_dest;
        got.sew = bus.wb_sew;
        got.mask = bus.wb_mask;
        got.opc = bus.wb_opc;
        got.result = bus.wb_result;
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb @cycle %0d: got wb_valid=1 dest=%0d expected no writeback", cyc, bus.wb_dest);
        end else begin
          chk("wb_pkt", 160'(got), 160'(sbq[idx].pkt));
          sbq.delete(idx);
        end
      end
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_wb @cycle %0d: got no writeback expected dest=%0d at cycle %0d", cyc, sbq[i].pkt.dest, sbq[i].cyc);
          sbq.delete(i);
        end
      end
    end
  end

  // One issue cycle: drive fields, check issue_ready, push the expected writeback.
  task automatic drv(input bit v, input bit mul, input logic [4:0] dest, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] c, input bit exp_rdy,
                     input bit fl, input bit expect_wb);
    exp_t e;
    @(posedge clk);
    #1;
    bus.issue_valid  = v;
    bus.issue_is_mul = mul;
    bus.issue_op     = {4'd0, dest};
    bus.issue_sew    = dest[2:0];
    bus.issue_dest   = dest;
    bus.issue_opa    = a;
    bus.issue_opb    = b;
    bus.issue_opc    = c;
    bus.issue_mask   = {dest[3:0], ~dest[3:0]};
    bus.flush        = fl;
    @(negedge clk);
    chk("issue_ready", 160'(bus.issue_ready), 160'(exp_rdy));
    if (v && exp_rdy && expect_wb) begin
      e.cyc        = cyc + (mul ? ML : 1);
      e.pkt.dest   = dest;
      e.pkt.sew    = dest[2:0];
      e.pkt.mask   = {dest[3:0], ~dest[3:0]};
      e.pkt.opc    = c;
      e.pkt.result = mul ? a * b : a ^ b;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input bit exp_rdy);
    drv(1'b0, 1'b0, 5'd31, 64'hDEAD_0000_0000_BEEF, 64'h0000_0000_0000_1234, 64'd0, exp_rdy, 1'b0, 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; cyc = 0; checks = 0; errors = 0;
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_is_mul = 1'b0; bus.issue_op = '0;
    bus.issue_sew = '0; bus.issue_dest = '0; bus.issue_opa = '0; bus.issue_opb = '0;
    bus.issue_opc = '0; bus.issue_mask = '0; bus.wait_load_in = 1'b0; bus.load_dest_in = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_wb_valid", 160'(bus.wb_valid), 160'd0);
    chk("rst_wb_result", 160'(bus.wb_result), 160'd0);
    chk("rst_wb_dest", 160'(bus.wb_dest), 160'd0);
    chk("rst_issue_ready", 160'(bus.issue_ready), 160'd1);
    chk("rst_fu_opa", 160'(bus.fu_opa), 160'd0);
    chk("rst_wait_load_out", 160'(bus.wait_load_out), 160'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Simple op returning 0xAB, then back-to-back simples.
    drv(1'b1, 1'b0, 5'd3, 64'h0000_0000_0000_00AB, 64'd0, 64'h1111, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b0, 5'd4, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h2222, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b0, 5'd5, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'h3333, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b0, 5'd6, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h4444, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("idle_hold_dest", 160'(bus.wb_dest), 160'd6);

    // Multiply dest 7; operands held; simple blocked two cycles later, accepted next.
    drv(1'b1, 1'b1, 5'd7, 64'h0000_0000_0001_0003, 64'h0000_0000_0000_0005, 64'h7777, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("fu_opa_hold1", 160'(bus.fu_opa), 160'h0000_0000_0001_0003);
    chk("fu_opb_hold1", 160'(bus.fu_opb), 160'h0000_0000_0000_0005);
    drv(1'b1, 1'b0, 5'd8, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_000F, 64'h8888, 1'b0, 1'b0, 1'b1);
    chk("fu_opa_hold2", 160'(bus.fu_opa), 160'h0000_0000_0001_0003);
    drv(1'b1, 1'b0, 5'd8, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_000F, 64'h8888, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Multiply followed by a simple: the simple retires first.
    drv(1'b1, 1'b1, 5'd10, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_0010, 64'hA0A0, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b0, 5'd11, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0F0F, 64'hB0B0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Three back-to-back multiplies retire in order; simple path blocked while they drain.
    drv(1'b1, 1'b1, 5'd1, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 64'h0001, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 5'd2, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0011, 64'h0002, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 5'd3, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0100, 64'h0003, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Multiply killed by a flush in the next cycle; an offer during flush is refused.
    drv(1'b1, 1'b1, 5'd12, 64'h0000_0000_0000_0009, 64'h0000_0000_0000_0009, 64'h0C0C, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 5'd13, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0004, 64'h0D0D, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Load-wait passthrough with one cycle of delay.
    @(posedge clk);
    #1;
    bus.wait_load_in = 1'b1;
    bus.load_dest_in = 5'd9;
    @(negedge clk);
    chk("wait_load_same_cycle", 160'(bus.wait_load_out), 160'd0);
    @(negedge clk);
    chk("wait_load_next_cycle", 160'(bus.wait_load_out), 160'd1);
    chk("load_dest_next_cycle", 160'(bus.load_dest_out), 160'd9);

    // Reset in the middle of a multiply while a simple result is on the writeback port.
    drv(1'b1, 1'b1, 5'd13, 64'h0000_0000_0000_0006, 64'h0000_0000_0000_0006, 64'h0E0E, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 5'd14, 64'h0000_0000_0000_00CC, 64'd0, 64'h0F0F, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    chk("pre_rst_wb_valid", 160'(bus.wb_valid), 160'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wb_valid", 160'(bus.wb_valid), 160'd0);
    chk("mid_rst_wb_result", 160'(bus.wb_result), 160'd0);
    chk("mid_rst_wb_dest", 160'(bus.wb_dest), 160'd0);
    chk("mid_rst_issue_ready", 160'(bus.issue_ready), 160'd1);
    chk("mid_rst_fu_opa", 160'(bus.fu_opa), 160'd0);
    chk("mid_rst_wait_load_out", 160'(bus.wait_load_out), 160'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("post_rst_wait_load_out0", 160'(bus.wait_load_out), 160'd0);
    @(negedge clk);
    chk("post_rst_wait_load_out1", 160'(bus.wait_load_out), 160'd1);
    repeat (6) idle(1'b1);

    chk("sb_drain", 160'(sbq.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
